// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the note tone generator: note-to-preset table,
// rest index and play-source encoding.
package note_tone_gen_pkg;

    // Note index 0 is the rest (silent) entry of the table.
    localparam int REST_IDX = 0;

    // Play source selected by MODE.
    typedef enum logic {
        MODE_ROM = 1'b0,
        MODE_KEY = 1'b1
    } mode_e;

    // Divider presets: the half-period is 2**DIV_W - preset cycles.
    // Index 0 (rest) is all-ones for an 11-bit divider.
    function automatic int tone_tab(input int idx);
        case (idx)
            1:       return 773;
            2:       return 912;
            3:       return 1036;
            4:       return 1116;
            5:       return 1197;
            6:       return 1290;
            7:       return 1372;
            8:       return 1410;
            9:       return 1480;
            10:      return 1542;
            11:      return 1570;
            12:      return 1622;
            13:      return 1647;
            14:      return 1668;
            15:      return 1728;
            default: return 2047;
        endcase
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note/keypad input bundle and tone outputs of the note tone generator.
// master drives note requests, slave is the generator itself.
interface note_tone_gen_if #(
    parameter int NOTE_W = 4,
    parameter int DIV_W  = 11,
    parameter int OCT_W  = 2
);
    logic              MODE;
    logic [NOTE_W-1:0] INX;
    logic              INX_VLD;
    logic [NOTE_W-1:0] KEYVALUE;
    logic              KEY_VLD;
    logic [OCT_W-1:0]  OCT;
    logic [NOTE_W-1:0] CODE;
    logic              H;
    logic [DIV_W-1:0]  TO;
    logic              SPK;
    logic              ACTIVE;

    modport master (
        output MODE, INX, INX_VLD, KEYVALUE, KEY_VLD, OCT,
        input  CODE, H, TO, SPK, ACTIVE
    );

    modport slave (
        input  MODE, INX, INX_VLD, KEYVALUE, KEY_VLD, OCT,
        output CODE, H, TO, SPK, ACTIVE
    );
endinterface

// File: rtl/note_tone_gen_div.sv
// Programmable tone divider: loadable down-counter plus SPK toggle flop.
// tick marks the last cycle of a half-period (counter at zero).
module note_tone_gen_div #(
    parameter int DIV_W = 11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    input  logic             hold,
    output logic             tick,
    output logic             spk
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             spk_q, spk_d;

    assign tick = (cnt_q == '0);
    assign spk  = spk_q;

    // Count down and reload on each toggle point; a silent note freezes the
    // counter and pulls SPK low so the pin never carries a partial pulse.
    always_comb begin
        cnt_d = cnt_q;
        spk_d = spk_q;
        if (load) begin
            cnt_d = period;
        end else if (!hold) begin
            cnt_d = tick ? period : cnt_q - 1'b1;
        end
        if (hold) begin
            spk_d = 1'b0;
        end else if (tick) begin
            spk_d = ~spk_q;
        end
    end

    // Counter and output flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            spk_q <= spk_d;
        end
    end
endmodule

// File: rtl/note_tone_gen.sv
// Note tone generator: picks the ROM or keypad note by MODE, holds it as a
// pending request, applies it on a toggle point (or at once from rest) and
// drives the tone divider with the table preset shifted by OCT.
// Optional feature macro NOTE_GATE_EN: keypad release sustain counter that
// schedules a rest SUSTAIN_CYC cycles after the key is let go.
module note_tone_gen
    import note_tone_gen_pkg::*;
#(
    parameter int NOTE_W      = 4,
    parameter int DIV_W       = 11,
    parameter int OCT_W       = 2,
    parameter int SUSTAIN_CYC = 1024
) (
    input logic            CLK,
    input logic            RST_N,
    note_tone_gen_if.slave bus
);
    localparam logic [NOTE_W-1:0] REST_CODE = NOTE_W'(REST_IDX);
    localparam logic [DIV_W-1:0]  TO_REST   = '1;

    function automatic logic [DIV_W-1:0] preset_of(input logic [NOTE_W-1:0] idx);
        if (idx == REST_CODE) return TO_REST;
        return DIV_W'(tone_tab(int'(idx)));
    endfunction

    // Reload value N_eff-1 with N_eff = max(1, (2**DIV_W - preset) >> oct).
    function automatic logic [DIV_W-1:0] period_m1(input logic [DIV_W-1:0] to,
                                                   input logic [OCT_W-1:0] oct);
        logic [DIV_W:0] n;
        logic [DIV_W:0] n_m1;
        n = ({1'b1, {DIV_W{1'b0}}} - {1'b0, to}) >> oct;
        if (n == '0) n = {{DIV_W{1'b0}}, 1'b1};
        n_m1 = n - 1'b1;
        return n_m1[DIV_W-1:0];
    endfunction

    logic              mode_q, mode_d;
    logic              key_vld_q, key_vld_d;
    logic [NOTE_W-1:0] key_val_q, key_val_d;
    logic [NOTE_W-1:0] code_q, code_d;
    logic [DIV_W-1:0]  to_q, to_d;
    logic              pend_vld_q, pend_vld_d;
    logic [NOTE_W-1:0] pend_code_q, pend_code_d;

    logic              mode_chg, samp, gate_fire, new_vld, eff_vld, apply;
    logic              load, hold, div_tick, tone_tick;
    logic [NOTE_W-1:0] samp_code, new_code, eff_code;
    logic [DIV_W-1:0]  period;

    // Source select: ROM strobe, or keypad press / value change while held.
    // The cycle MODE changes samples nothing from either source.
    always_comb begin
        mode_d    = bus.MODE;
        mode_chg  = (bus.MODE != mode_q);
        samp      = 1'b0;
        samp_code = bus.INX;
        key_vld_d = 1'b0;
        key_val_d = bus.KEYVALUE;
        if (!mode_chg) begin
            if (bus.MODE == MODE_ROM) begin
                samp = bus.INX_VLD;
            end else begin
                samp      = bus.KEY_VLD && (!key_vld_q || (bus.KEYVALUE != key_val_q));
                samp_code = bus.KEYVALUE;
                key_vld_d = bus.KEY_VLD;
            end
        end
    end

`ifdef NOTE_GATE_EN
    localparam int GATE_W = (SUSTAIN_CYC > 2) ? $clog2(SUSTAIN_CYC) : 1;

    logic              gate_run_q, gate_run_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic              key_fall;

    // Release sustain: start on key release, cancel on a new key or MODE
    // change, and request a rest once the count expires.
    always_comb begin
        key_fall   = !mode_chg && (bus.MODE == MODE_KEY) && key_vld_q && !bus.KEY_VLD;
        gate_fire  = gate_run_q && (gate_cnt_q == '0) && !samp;
        gate_run_d = gate_run_q;
        gate_cnt_d = gate_cnt_q;
        if (mode_chg || samp) begin
            gate_run_d = 1'b0;
        end else if (key_fall) begin
            gate_run_d = 1'b1;
            gate_cnt_d = GATE_W'(SUSTAIN_CYC - 1);
        end else if (gate_run_q) begin
            if (gate_cnt_q == '0) gate_run_d = 1'b0;
            else                  gate_cnt_d = gate_cnt_q - 1'b1;
        end
    end

    // Sustain counter state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gate_run_q <= 1'b0;
            gate_cnt_q <= '0;
        end else begin
            gate_run_q <= gate_run_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end
`else
    logic unused_sustain;
    assign gate_fire      = 1'b0;
    assign unused_sustain = (SUSTAIN_CYC != 0);
`endif

    // Pending request (last write wins, re-strobing the sounding note drops
    // any pending change) and apply control: at once from rest, otherwise
    // only on a toggle point so a half-period is never cut short.
    always_comb begin
        new_vld  = samp || gate_fire;
        new_code = samp ? samp_code : REST_CODE;
        if (new_vld) begin
            eff_vld  = (new_code != code_q);
            eff_code = new_code;
        end else begin
            eff_vld  = pend_vld_q;
            eff_code = pend_code_q;
        end
        tone_tick   = div_tick && (code_q != REST_CODE);
        apply       = eff_vld && ((code_q == REST_CODE) || tone_tick);
        code_d      = code_q;
        pend_vld_d  = eff_vld;
        pend_code_d = eff_code;
        load        = 1'b0;
        if (mode_chg) begin
            code_d     = REST_CODE;
            pend_vld_d = 1'b0;
        end else if (apply) begin
            code_d     = eff_code;
            pend_vld_d = 1'b0;
            load       = 1'b1;
        end
        to_d   = preset_of(code_d);
        hold   = (code_q == REST_CODE) || (code_d == REST_CODE);
        period = period_m1(to_d, bus.OCT);
    end

    // Note, source-tracking and pending registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q      <= MODE_ROM;
            key_vld_q   <= 1'b0;
            key_val_q   <= '0;
            code_q      <= REST_CODE;
            to_q        <= TO_REST;
            pend_vld_q  <= 1'b0;
            pend_code_q <= REST_CODE;
        end else begin
            mode_q      <= mode_d;
            key_vld_q   <= key_vld_d;
            key_val_q   <= key_val_d;
            code_q      <= code_d;
            to_q        <= to_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
        end
    end

    note_tone_gen_div #(.DIV_W(DIV_W)) u_tone_div (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .load   (load),
        .period (period),
        .hold   (hold),
        .tick   (div_tick),
        .spk    (bus.SPK)
    );

    assign bus.CODE   = code_q;
    assign bus.TO     = to_q;
    assign bus.H      = code_q[NOTE_W-1];
    assign bus.ACTIVE = (code_q != REST_CODE);
endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed scenarios followed by randomized note
// changes, checked against half-period lengths computed from the preset
// table and the octave-shift formula.
module tb_note_tone_gen;
    localparam int NOTE_W = 4;
    localparam int DIV_W  = 11;
    localparam int OCT_W  = 2;
`ifdef NOTE_GATE_EN
    localparam int SUSTAIN = 16;
`else
    localparam int SUSTAIN = 1024;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_tone_gen_if #(.NOTE_W(NOTE_W), .DIV_W(DIV_W), .OCT_W(OCT_W)) bus ();

    note_tone_gen #(
        .NOTE_W(NOTE_W), .DIV_W(DIV_W), .OCT_W(OCT_W), .SUSTAIN_CYC(SUSTAIN)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int presets [16] = '{2047, 773, 912, 1036, 1116, 1197, 1290, 1372,
                         1410, 1480, 1542, 1570, 1622, 1647, 1668, 1728};

    // Cycles per SPK half-period for a note at a given octave shift.
    function automatic int neff(input int idx, input int oct);
        int n;
        n = (2048 - presets[idx]) >> oct;
        return (n < 1) ? 1 : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("%-18s observed %0d expected %0d", tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Cycles from now until SPK changes level (bounded).
    task automatic measure(output int n);
        logic s;
        s = bus.SPK;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.SPK === s && n < 5000);
    endtask

    task automatic strobe_inx(input int idx);
        bus.INX     = NOTE_W'(idx);
        bus.INX_VLD = 1'b1;
        cyc();
        bus.INX_VLD = 1'b0;
    endtask

    task automatic wait_code(input int idx, output int n);
        n = 0;
        while (bus.CODE !== NOTE_W'(idx) && n < 5000) begin
            cyc();
            n++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_code"},   32'(bus.CODE),   0);
        check({tag, "_h"},      32'(bus.H),      0);
        check({tag, "_to"},     32'(bus.TO),     2047);
        check({tag, "_spk"},    32'(bus.SPK),    0);
        check({tag, "_active"}, 32'(bus.ACTIVE), 0);
    endtask

    initial begin
        int n, m, idx, idx2, oct, d;
        bus.MODE = 1'b0; bus.INX = '0; bus.INX_VLD = 1'b0;
        bus.KEYVALUE = '0; bus.KEY_VLD = 1'b0; bus.OCT = '0;
        repeat (3) cyc();
        check_reset("rst");
        rst_n = 1'b1;
        cyc();

        // ROM note 8 from rest
        strobe_inx(8);
        check("n8_code", 32'(bus.CODE), 8);
        check("n8_to", 32'(bus.TO), 1410);
        check("n8_h", 32'(bus.H), 1);
        check("n8_active", 32'(bus.ACTIVE), 1);
        check("n8_spk", 32'(bus.SPK), 0);
        measure(n); check("n8_first", n, 638);
        measure(n); check("n8_half", n, 638);

        // octave change takes effect from the next reload
        bus.OCT = 2'd1;
        measure(n); check("oct1_cur", n, 638);
        measure(n); check("oct1_next", n, 319);
        bus.OCT = 2'd0;
        measure(n); check("oct0_cur", n, 319);

        // same note re-strobed: phase continues
        repeat (50) cyc();
        strobe_inx(8);
        measure(m); check("restrobe", 51 + m, 638);

        // change mid half-period waits for the toggle point
        repeat (100) cyc();
        strobe_inx(1);
        check("mid_code_hold", 32'(bus.CODE), 8);
        measure(m); check("mid_half", 101 + m, 638);
        check("mid_code_new", 32'(bus.CODE), 1);
        check("mid_to_new", 32'(bus.TO), 773);
        check("mid_h_new", 32'(bus.H), 0);
        measure(n); check("n1_half", n, 1275);
        bus.OCT = 2'd3;
        measure(n); check("n1_oct3_cur", n, 1275);
        measure(n); check("n1_oct3", n, 159);

        // asynchronous reset while the tone is high
        if (bus.SPK !== 1'b1) measure(n);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.OCT = 2'd0;
        cyc();

        // MODE flip mid-note, then simultaneous strobes in keypad mode
        strobe_inx(1);
        measure(n); check("t5_n1", n, 1275);
        check("t5_spk_high", 32'(bus.SPK), 1);
        bus.MODE = 1'b1;
        cyc();
        check("flip_code", 32'(bus.CODE), 0);
        check("flip_spk", 32'(bus.SPK), 0);
        check("flip_active", 32'(bus.ACTIVE), 0);
        bus.INX = 4'd3; bus.INX_VLD = 1'b1;
        bus.KEYVALUE = 4'd5; bus.KEY_VLD = 1'b1;
        cyc();
        bus.INX_VLD = 1'b0;
        check("key_code", 32'(bus.CODE), 5);
        check("key_to", 32'(bus.TO), 1197);
        measure(n); check("key_half", n, neff(5, 0));
        bus.KEY_VLD = 1'b0;
`ifdef NOTE_GATE_EN
        n = 0;
        while (bus.CODE === 4'd5 && n < 3000) begin
            cyc();
            n++;
        end
        check("gate_window", 32'(n >= 17 && n <= 17 + neff(5, 0)), 1);
        check("gate_rest", 32'(bus.CODE), 0);
        bus.KEY_VLD = 1'b1;
        cyc();
        check("gate_press", 32'(bus.CODE), 5);
        bus.KEY_VLD = 1'b0;
        repeat (8) cyc();
        bus.KEY_VLD = 1'b1;
        repeat (16 + 2 * neff(5, 0)) cyc();
        check("gate_cancel", 32'(bus.CODE), 5);
`else
        repeat (300) cyc();
        check("release_code", 32'(bus.CODE), 5);
        check("release_active", 32'(bus.ACTIVE), 1);
`endif
        bus.MODE = 1'b0;
        cyc();
        check("back_rom_code", 32'(bus.CODE), 0);
        bus.KEY_VLD = 1'b0;

        // randomized note changes in ROM mode
        for (int it = 0; it < 5; it++) begin
            idx  = int'($urandom_range(1, 15));
            oct  = int'($urandom_range(0, 3));
            idx2 = 1 + ((idx - 1 + int'($urandom_range(1, 14))) % 15);
            bus.OCT = OCT_W'(oct);
            strobe_inx(idx);
            check("rnd_code", 32'(bus.CODE), idx);
            check("rnd_to", 32'(bus.TO), presets[idx]);
            check("rnd_h", 32'(bus.H), 32'(idx >= 8));
            measure(n); check("rnd_first", n, neff(idx, oct));
            d = int'($urandom_range(0, neff(idx, oct) - 3));
            repeat (d) cyc();
            strobe_inx(idx2);
            check("rnd_code_hold", 32'(bus.CODE), idx);
            measure(m); check("rnd_cur_half", d + 1 + m, neff(idx, oct));
            check("rnd_code2", 32'(bus.CODE), idx2);
            check("rnd_to2", 32'(bus.TO), presets[idx2]);
            measure(n); check("rnd_half2", n, neff(idx2, oct));
            strobe_inx(0);
            wait_code(0, n);
            check("rnd_rest_code", 32'(bus.CODE), 0);
            check("rnd_rest_lat", 32'(n <= neff(idx2, oct)), 1);
            check("rnd_rest_spk", 32'(bus.SPK), 0);
            check("rnd_rest_active", 32'(bus.ACTIVE), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
